encoder_7to3: RTL and testbench
===============================

// Module: encoder_7to3
// PURPOSE
//   Registered 7-to-3 priority encoder. Converts a 7-bit request vector into
//   a 3-bit index, where input bit i maps to code i+1 and code 0 means no
//   request. Used as a small select/index generator in the datapath.
//   Adds a valid flag and a multi-hot flag, both registered with the code.
// PARAMETERS
//   none (widths fixed: 7 inputs, 3-bit code)
// PORTS
//   clk        in   1  single system clock; all state updates on rising edge
//   rst        in   1  asynchronous, active-high reset
//   in_vec     in   7  request vector; bit 0 = lowest priority, bit 6 = highest
//   code       out  3  encoded index, registered
//   valid      out  1  registered; 1 when any in_vec bit was set
//   multi_hot  out  1  registered; 1 when two or more in_vec bits were set
// BEHAVIOUR
//   - Reset: while rst=1, independent of clk: code=3'd0, valid=0,
//     multi_hot=0. Release is taken at the next rising clk edge.
//   - Latency: one cycle. in_vec sampled at rising edge N appears on outputs
//     after edge N and holds until edge N+1. No combinational in->out path.
//   - Encoding for one-hot in_vec: bit0->1, bit1->2, bit2->3, bit3->4,
//     bit4->5, bit5->6, bit6->7.
//   - in_vec=0: code=0, valid=0, multi_hot=0.
//   - Multi-hot: the highest set bit wins (code = index of MSB set + 1),
//     valid=1, multi_hot=1.
//   - multi_hot = popcount(in_vec) >= 2; valid = |in_vec.
//   - No enable and no handshake: a new sample is registered every cycle.
//   - Reset mid-stream clears outputs immediately. The first post-reset
//     edge registers the current in_vec normally.
//   - X/Z on in_vec is not defined. Output is unconstrained in that case.
// TESTING
//   1. Assert rst, drive in_vec=7'h7F -> code=0, valid=0, multi_hot=0
//      while rst=1, including without a clock edge.
//   2. in_vec=7'b0000000 -> after 1 edge: code=0, valid=0, multi_hot=0.
//   3. Walking one, 7'b0000001 .. 7'b1000000, one per cycle -> code=1..7
//      on the following cycle, valid=1, multi_hot=0.
//   4. in_vec=7'b0100101 -> code=6, valid=1, multi_hot=1;
//      in_vec=7'b1111111 -> code=7, valid=1, multi_hot=1.
//   5. Latency check: change in_vec mid-cycle -> outputs do not change until
//      the next rising edge.
//   6. Assert rst asynchronously while code=5 -> code=0 at once; deassert
//      with in_vec=7'b0001000 -> code=4 after the next edge.

Source files
------------

// File: rtl/encoder_7to3.sv
// Registered 7-to-3 priority encoder: highest set request bit wins (bit i -> code i+1),
// with registered valid and multi-hot flags. One cycle latency, no combinational in->out path.
module encoder_7to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] in_vec,
    output logic [2:0] code,
    output logic       valid,
    output logic       multi_hot
);

    localparam int unsigned IN_W   = 7;
    localparam int unsigned CODE_W = 3;

    logic [CODE_W-1:0] code_c;
    logic              valid_c;
    logic              multi_hot_c;

    // Priority encode: ascending scan so the highest set bit overrides lower ones.
    always_comb begin
        code_c = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (in_vec[i]) begin
                code_c = CODE_W'(i + 1);
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    always_comb begin
        valid_c     = |in_vec;
        multi_hot_c = |(in_vec & (in_vec - IN_W'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code      <= '0;
            valid     <= 1'b0;
            multi_hot <= 1'b0;
        end else begin
            code      <= code_c;
            valid     <= valid_c;
            multi_hot <= multi_hot_c;
        end
    end

endmodule

// File: tb/tb_encoder_7to3.sv
// Self-checking bench for encoder_7to3: expected {code, valid, multi_hot} queued when
// a vector is driven, popped and compared once the registered outputs update.
module tb_encoder_7to3;

    logic       clk;
    logic       rst;
    logic [6:0] in_vec;
    logic [2:0] code;
    logic       valid;
    logic       multi_hot;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [4:0] exp_q[$];
    logic [4:0] held;

    encoder_7to3 dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .code      (code),
        .valid     (valid),
        .multi_hot (multi_hot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed as {code, valid, multi_hot}
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got code=%0d valid=%0b multi_hot=%0b, want code=%0d valid=%0b multi_hot=%0b",
                     tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Reference: MSB position via clog2 of (v+1), multi-hot via popcount.
    function automatic logic [4:0] model(input logic [6:0] v);
        int unsigned c;
        c = $clog2(int'(v) + 1);
        return {3'(c), (v != 7'd0), ($countones(v) >= 2)};
    endfunction

    function automatic logic [4:0] outs();
        return {code, valid, multi_hot};
    endfunction

    // Drive mid-cycle, queue expectation, compare just after the sampling edge.
    task automatic drive(input string tag, input logic [6:0] v);
        logic [4:0] exp;
        @(negedge clk);
        in_vec = v;
        exp_q.push_back(model(v));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, outs(), exp);
        end
    endtask

    initial begin
        rst    = 1'b0;
        in_vec = 7'h00;

        // Async reset with no clock edge yet
        #1;
        rst    = 1'b1;
        in_vec = 7'h7F;
        #1;
        check("reset_no_edge", outs(), 5'b000_0_0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_edges", outs(), 5'b000_0_0);

        // Release on a falling edge with a zero request
        @(negedge clk);
        in_vec = 7'h00;
        rst    = 1'b0;
        drive("zero", 7'h00);

        for (int i = 0; i < 7; i++) begin
            drive($sformatf("walk_bit%0d", i), 7'(1 << i));
        end

        drive("multi_0100101", 7'b0100101);
        drive("all_ones", 7'b1111111);
        drive("pair_low", 7'b0000011);
        drive("zero_again", 7'b0000000);

        for (int i = 0; i < 6; i++) begin
            logic [6:0] r;
            r = 7'($urandom_range(0, 127));
            drive($sformatf("rand_%0d", i), r);
        end

        // Latency: a mid-cycle input change must not reach the outputs before the edge
        drive("lat_before", 7'b0000100);
        held = outs();
        @(negedge clk);
        in_vec = 7'b1000001;
        exp_q.push_back(model(7'b1000001));
        #2;
        check("lat_hold", outs(), held);
        @(posedge clk);
        #1;
        check("lat_after", outs(), exp_q.pop_front());

        // Asynchronous reset while code=5, then release into code=4
        drive("pre_reset_code5", 7'b0010000);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", outs(), 5'b000_0_0);
        @(negedge clk);
        in_vec = 7'b0001000;
        rst    = 1'b0;
        exp_q.push_back(model(7'b0001000));
        @(posedge clk);
        #1;
        check("post_reset_code4", outs(), exp_q.pop_front());
        check("post_reset_exact", outs(), 5'b100_1_0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
